// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM blitter.
package sprite_pkg;

   localparam int unsigned SPR_W  = 80;
   localparam int unsigned SPR_H  = 60;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned PIX_W  = 4;
   localparam int unsigned SCR_W  = 640;
   localparam int unsigned SCR_H  = 480;
   localparam int unsigned COL_W  = $clog2(SPR_W);
   localparam int unsigned ROW_W  = $clog2(SPR_H);

   localparam logic [PIX_W-1:0]  TRANSPARENT = '0;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SPR_W * SPR_H - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} blit_state_t;

   typedef struct packed {
      logic [9:0]       x;
      logic [8:0]       y;
      logic [PIX_W-1:0] data;
      logic             vis;
   } blit_pix_t;

   function automatic logic on_screen(input logic [10:0] x, input logic [9:0] y);
      return (x < 11'(SCR_W)) && (y < 10'(SCR_H));
   endfunction

endpackage

// File: rtl/blit_skid_buf.sv
// One-entry skid register between the ROM data stage and the pixel output stage.
module blit_skid_buf
   import sprite_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      in_valid_i,
   input  blit_pix_t in_pix_i,
   output logic      in_ready_o,
   output logic      out_valid_o,
   output blit_pix_t out_pix_o,
   input  logic      out_ready_i
);

   logic      full_q, full_d;
   blit_pix_t pix_q, pix_d;

   always_comb begin
      full_d = full_q;
      pix_d  = pix_q;
      if (full_q) begin
         if (out_ready_i) begin
            full_d = 1'b0;
         end
      end else if (in_valid_i && !out_ready_i) begin
         full_d = 1'b1;
         pix_d  = in_pix_i;
      end
   end

   // A held entry always goes out ahead of anything new from the ROM.
   assign in_ready_o  = !full_q;
   assign out_valid_o = full_q || in_valid_i;
   assign out_pix_o   = full_q ? pix_q : in_pix_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         pix_q  <= '0;
      end else begin
         full_q <= full_d;
         pix_q  <= pix_d;
      end
   end

endmodule

// File: rtl/sprite_blit_reader.sv
// Walks the sprite ROM in raster order and emits clipped, non-transparent pixel writes
// toward the frame buffer, tolerating backpressure through a skid register.
module sprite_blit_reader
   import sprite_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic [9:0]        pos_x,
   input  logic [8:0]        pos_y,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              fb_we,
   output logic [9:0]        fb_x,
   output logic [8:0]        fb_y,
   output logic [PIX_W-1:0]  fb_data,
   input  logic              fb_ready
);

   localparam logic [ADDR_W-1:0] PRE_LAST = LAST_ADDR - 1'b1;

   blit_state_t       state_q, state_d;
   logic [9:0]        pos_x_q, pos_x_d;
   logic [8:0]        pos_y_q, pos_y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ROW_W-1:0]  row_q, row_d, s2_row_q, s2_row_d;
   logic [COL_W-1:0]  col_q, col_d, s2_col_q, s2_col_d;
   logic              s1_vld_q, s1_vld_d;
   logic              s2_vld_q, s2_vld_d;
   logic              s3_vld_q, s3_vld_d;
   blit_pix_t         s3_pix_q, s3_pix_d;

   blit_pix_t         s2_pix, skid_pix;
   logic [10:0]       x_sum;
   logic [9:0]        y_sum;
   logic              stall, s3_adv, s2_ready, skid_vld, issue, drained;

   assign stall  = fb_we && !fb_ready;
   assign s3_adv = !stall;

   always_comb begin
      x_sum       = {1'b0, pos_x_q} + 11'(s2_col_q);
      y_sum       = {1'b0, pos_y_q} + 10'(s2_row_q);
      s2_pix.x    = x_sum[9:0];
      s2_pix.y    = y_sum[8:0];
      s2_pix.data = rom_data;
      s2_pix.vis  = on_screen(x_sum, y_sum) && (rom_data != TRANSPARENT);
   end

   blit_skid_buf u_skid (
      .clk_i       (Clk),
      .rst_ni      (Reset_n),
      .in_valid_i  (s2_vld_q),
      .in_pix_i    (s2_pix),
      .in_ready_o  (s2_ready),
      .out_valid_o (skid_vld),
      .out_pix_o   (skid_pix),
      .out_ready_i (s3_adv)
   );

   // While the skid is full the S2 pixel is held by leaving rom_addr on its address,
   // so the ROM keeps presenting the same data; issuing must wait until the skid empties.
   assign issue   = (state_q == FETCH) && s3_adv && s2_ready;
   assign drained = !s1_vld_q && !s2_vld_q && s2_ready && (!s3_vld_q || s3_adv);

   always_comb begin
      state_d  = state_q;
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      addr_d   = addr_q;
      row_d    = row_q;
      col_d    = col_q;
      s1_vld_d = s1_vld_q;
      s2_vld_d = s2_vld_q;
      s2_row_d = s2_row_q;
      s2_col_d = s2_col_q;
      s3_vld_d = s3_vld_q;
      s3_pix_d = s3_pix_q;

      if (s2_ready) begin
         s2_vld_d = s1_vld_q;
         s2_row_d = row_q;
         s2_col_d = col_q;
         s1_vld_d = 1'b0;
      end

      if (s3_adv) begin
         s3_vld_d = skid_vld;
         if (skid_vld) begin
            s3_pix_d = skid_pix;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               pos_x_d  = pos_x;
               pos_y_d  = pos_y;
               addr_d   = '0;
               row_d    = '0;
               col_d    = '0;
               s1_vld_d = 1'b1;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (issue) begin
               addr_d   = addr_q + 1'b1;
               s1_vld_d = 1'b1;
               if (col_q == COL_W'(SPR_W - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (addr_q == PRE_LAST) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drained) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         addr_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s2_row_q <= '0;
         s2_col_q <= '0;
         s3_vld_q <= 1'b0;
         s3_pix_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         addr_q   <= addr_d;
         row_q    <= row_d;
         col_q    <= col_d;
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s2_row_q <= s2_row_d;
         s2_col_q <= s2_col_d;
         s3_vld_q <= s3_vld_d;
         s3_pix_q <= s3_pix_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign rom_addr = addr_q;
   assign fb_we    = s3_vld_q && s3_pix_q.vis;
   assign fb_x     = s3_pix_q.x;
   assign fb_y     = s3_pix_q.y;
   assign fb_data  = s3_pix_q.data;

endmodule

// File: tb/tb_sprite_blit_reader.sv
// Scoreboard bench for sprite_blit_reader: stimulus queues expected writes and done
// events, a forked monitor pops and compares them at every falling edge.
module tb_sprite_blit_reader;

   logic        Clk;
   logic        Reset_n;
   logic        start;
   logic [9:0]  pos_x;
   logic [8:0]  pos_y;
   logic        busy;
   logic        done;
   logic [12:0] rom_addr;
   logic [3:0]  rom_data;
   logic        fb_we;
   logic [9:0]  fb_x;
   logic [8:0]  fb_y;
   logic [3:0]  fb_data;
   logic        fb_ready;

   sprite_blit_reader dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .start    (start),
      .pos_x    (pos_x),
      .pos_y    (pos_y),
      .busy     (busy),
      .done     (done),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .fb_we    (fb_we),
      .fb_x     (fb_x),
      .fb_y     (fb_y),
      .fb_data  (fb_data),
      .fb_ready (fb_ready)
   );

   typedef struct {
      int s;
      int lat;
      int n;
   } done_exp_t;

   logic [3:0]  mem [0:4799];
   logic [22:0] exp_q [$];
   done_exp_t   done_q [$];
   int          errors;
   int          checks;
   int          edge_cnt;
   int          wr_cnt;
   logic        bp_mode;
   logic        prev_done;
   logic        hold_vld;
   logic [23:0] hold_val;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   // ROM with one-cycle registered read latency
   always @(posedge Clk) rom_data <= mem[rom_addr];

   initial begin
      fb_ready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         fb_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon_step();
      done_exp_t d;
      logic [22:0] e;
      if (!Reset_n) begin
         exp_q.delete();
         done_q.delete();
         wr_cnt    = 0;
         hold_vld  = 1'b0;
         prev_done = 1'b0;
         return;
      end
      if (prev_done) begin
         check("done_one_cycle", done, 1'b0);
         check("busy_after_done", busy, 1'b0);
      end
      if (hold_vld) begin
         check("stall_hold", {fb_we, fb_x, fb_y, fb_data}, hold_val);
      end
      if (fb_we && fb_ready) begin
         wr_cnt++;
         check("write_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel_xyd", {fb_x, fb_y, fb_data}, e);
         end
      end
      hold_vld = fb_we && !fb_ready;
      hold_val = {fb_we, fb_x, fb_y, fb_data};
      if (done) begin
         check("done_expected", done_q.size() != 0, 1'b1);
         if (done_q.size() != 0) begin
            d = done_q.pop_front();
            if (d.lat != 0) begin
               check("done_latency", edge_cnt - d.s, d.lat);
            end
            check("write_count", wr_cnt, d.n);
            check("pixels_left", exp_q.size(), 0);
         end
         wr_cnt = 0;
      end
      prev_done = done;
   endtask

   task automatic fill_const(input logic [3:0] v);
      for (int i = 0; i < 4800; i++) mem[i] = v;
   endtask

   task automatic fill_addr();
      for (int i = 0; i < 4800; i++) mem[i] = 4'(i) | 4'd1;
   endtask

   task automatic fill_even_clear();
      for (int i = 0; i < 4800; i++) mem[i] = ((i % 80) % 2 == 0) ? 4'd0 : 4'd5;
   endtask

   task automatic push_blit(input int px, input int py);
      for (int r = 0; r < 60; r++) begin
         for (int c = 0; c < 80; c++) begin
            int x;
            int y;
            logic [3:0] d;
            x = px + c;
            y = py + r;
            d = mem[r * 80 + c];
            if (x < 640 && y < 480 && d != 4'd0) exp_q.push_back({10'(x), 9'(y), d});
         end
      end
   endtask

   // Start is sampled at the second edge below; pixel k is then expected after edge S+k+2.
   task automatic launch(input int px, input int py, input int n, input int lat);
      @(posedge Clk);
      #1;
      start = 1'b1;
      pos_x = 10'(px);
      pos_y = 9'(py);
      @(posedge Clk);
      #1;
      start = 1'b0;
      push_blit(px, py);
      done_q.push_back('{edge_cnt, lat, n});
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check("done_within_budget", done, 1'b1);
   endtask

   initial begin
      int n;
      errors    = 0;
      checks    = 0;
      wr_cnt    = 0;
      bp_mode   = 1'b0;
      prev_done = 1'b0;
      hold_vld  = 1'b0;
      hold_val  = '0;
      start     = 1'b0;
      pos_x     = '0;
      pos_y     = '0;
      Reset_n   = 1'b1;
      fill_const(4'd5);
      fork
         forever begin
            @(negedge Clk);
            mon_step();
         end
      join_none

      // Power-on reset values
      #1 Reset_n = 1'b0;
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_fb_we", fb_we, 1'b0);
      check("rst_rom_addr", rom_addr, 13'd0);
      check("rst_fb_xyd", {fb_x, fb_y, fb_data}, 23'd0);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      // Reset asserted mid-FETCH aborts with no done pulse
      launch(100, 50, 4800, 4802);
      n = 0;
      while (rom_addr != 13'd1234 && n < 3000) begin
         @(negedge Clk);
         n++;
      end
      check("reach_addr_1234", rom_addr, 13'd1234);
      #2 Reset_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_fb_we", fb_we, 1'b0);
      check("abort_rom_addr", rom_addr, 13'd0);
      check("abort_done", done, 1'b0);
      repeat (3) @(negedge Clk);
      #2 Reset_n = 1'b1;
      repeat (30) @(negedge Clk);
      check("no_done_after_abort", done, 1'b0);

      // Opaque blit
      launch(100, 50, 4800, 4802);
      wait_done(6000);
      repeat (3) @(negedge Clk);

      // Transparent even columns
      fill_even_clear();
      launch(100, 50, 2400, 4802);
      wait_done(6000);
      repeat (3) @(negedge Clk);

      // Clipping at the bottom-right screen edge
      fill_addr();
      launch(600, 450, 1200, 4802);
      wait_done(6000);
      repeat (3) @(negedge Clk);

      // Random backpressure
      bp_mode = 1'b1;
      launch(100, 50, 4800, 0);
      wait_done(40000);
      @(posedge Clk);
      #2 bp_mode = 1'b0;
      repeat (3) @(negedge Clk);

      // Command overlap: start during busy and in the DONE cycle is ignored
      launch(10, 20, 4800, 4802);
      repeat (100) @(posedge Clk);
      #1;
      start = 1'b1;
      pos_x = 10'd300;
      pos_y = 9'd300;
      @(posedge Clk);
      #1;
      start = 1'b0;
      pos_x = 10'd10;
      pos_y = 9'd20;
      wait_done(6000);
      start = 1'b1;
      pos_x = 10'd400;
      pos_y = 9'd200;
      @(posedge Clk);
      #1;
      check("idle_after_done", busy, 1'b0);
      pos_x = 10'd5;
      pos_y = 9'd7;
      @(posedge Clk);
      #1;
      start = 1'b0;
      push_blit(5, 7);
      done_q.push_back('{edge_cnt, 4802, 4800});
      check("relaunch_busy", busy, 1'b1);
      wait_done(6000);
      repeat (3) @(negedge Clk);

      check("final_pixels_left", exp_q.size(), 0);
      check("final_done_left", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
